// File: rtl/bidsn_pkg.sv
// Shared types for the N-bidder auction engine: FSM states, control opcodes,
// error codes and the C_data field positions.
package bidsn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROUND   = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_LOAD_BAL = 4'd1,
    OP_SET_MASK = 4'd2,
    OP_SET_MIN  = 4'd3
  } op_e;

  typedef enum logic [1:0] {
    BERR_NONE   = 2'd0,
    BERR_STATE  = 2'd1,
    BERR_FUNDS  = 2'd2,
    BERR_REJECT = 2'd3
  } bid_err_e;

  typedef enum logic [2:0] {
    CERR_NONE     = 3'd0,
    CERR_BAD_OP   = 3'd1,
    CERR_NOT_IDLE = 3'd2,
    CERR_BAD_LANE = 3'd3,
    CERR_NO_MASK  = 3'd4
  } ctl_err_e;

  localparam int LANE_MSB = 31;
  localparam int LANE_LSB = 28;
  localparam logic [3:0] OP_MAX = 4'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bidsn_argmax.sv
// Combinational max / arg-max over N lane amounts. The scan starts at start_i
// and wraps, so among equal maxima the first lane at or after start_i wins.
module bidsn_argmax
  import bidsn_pkg::*;
#(
  parameter int N     = 4,
  parameter int AMT_W = 16,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N*AMT_W-1:0] amt_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic [AMT_W-1:0]   amt_o,
  output logic               valid_o
);

  logic [AMT_W-1:0] best_amt;
  logic [IDX_W-1:0] best_idx;
  int               pos;

  always_comb begin
    best_amt = '0;
    best_idx = '0;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      // strict compare keeps the earliest lane in scan order on a tie
      if (amt_i[pos*AMT_W +: AMT_W] > best_amt) begin
        best_amt = amt_i[pos*AMT_W +: AMT_W];
        best_idx = pos[IDX_W-1:0];
      end
    end
  end

  assign idx_o   = best_idx;
  assign amt_o   = best_amt;
  assign valid_o = |best_amt;

endmodule

// File: rtl/bidsn_engine.sv
// N-bidder auction engine with per-lane escrow of standing bids.
// Optional macro BIDSN_RR_TIEBREAK_EN: rotating tie-break pointer (else lowest lane wins ties).
//
// state      | meaning
// ST_IDLE    | accepts control ops, waits for C_start with a nonzero mask
// ST_ROUND   | lanes bid/retract, ends when C_start is sampled low
// ST_RESOLVE | one cycle: pick winner, refund losers, clear standing bids
module bidsn_engine
  import bidsn_pkg::*;
#(
  parameter int NUM_BIDDERS = 4,
  parameter int AMT_W       = 16,
  parameter int BAL_W       = 28
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_BIDDERS-1:0]       bid,
  input  logic [NUM_BIDDERS-1:0]       retract,
  input  logic [NUM_BIDDERS*AMT_W-1:0] bidAmt,
  input  logic                         C_start,
  input  logic [3:0]                   C_op,
  input  logic [31:0]                  C_data,
  output logic [NUM_BIDDERS-1:0]       ack,
  output logic [NUM_BIDDERS-1:0]       win,
  output logic [2*NUM_BIDDERS-1:0]     bidErr,
  output logic [2:0]                   err,
  output logic                         ready,
  output logic                         roundOver,
  output logic [NUM_BIDDERS*BAL_W-1:0] balance,
  output logic [AMT_W-1:0]             maxBid
);

  localparam int IDX_W = idx_w(NUM_BIDDERS);

  state_e                       state_q;
  logic                         ready_q;
  logic [NUM_BIDDERS-1:0]       mask_q;
  logic [AMT_W-1:0]             min_bid_q;
  logic [2:0]                   err_q;
  logic                         round_over_q;
  logic [AMT_W-1:0]             max_bid_q;
  logic [NUM_BIDDERS-1:0]       ack_q;
  logic [NUM_BIDDERS-1:0]       win_q;
  logic [2*NUM_BIDDERS-1:0]     bid_err_q;
  logic [BAL_W-1:0]             bal_q [NUM_BIDDERS];
  logic [AMT_W-1:0]             s_q   [NUM_BIDDERS];

  logic [BAL_W-1:0]             bal_d  [NUM_BIDDERS];
  logic [AMT_W-1:0]             s_d    [NUM_BIDDERS];
  logic [1:0]                   berr_d [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0]       ack_d;
  logic [NUM_BIDDERS-1:0]       win_d;

  logic [AMT_W-1:0]             amt_w   [NUM_BIDDERS];
  logic [BAL_W-1:0]             avail_w [NUM_BIDDERS];
  logic [NUM_BIDDERS*AMT_W-1:0] s_flat_w;
  logic [AMT_W-1:0]             min_eff_w;
  logic [3:0]                   load_lane_w;
  logic                         load_en_w;
  logic [IDX_W-1:0]             start_w;
  logic [IDX_W-1:0]             win_idx_w;
  logic [AMT_W-1:0]             win_amt_w;
  logic                         win_valid_w;

  for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_lane
    assign amt_w[g]                     = bidAmt[g*AMT_W +: AMT_W];
    assign avail_w[g]                   = bal_q[g] + BAL_W'(s_q[g]);
    assign s_flat_w[g*AMT_W +: AMT_W]   = s_q[g];
    assign balance[g*BAL_W +: BAL_W]    = bal_q[g];
  end

  // a zero minimum still rejects zero-amount bids
  assign min_eff_w   = (min_bid_q == '0) ? AMT_W'(1) : min_bid_q;
  assign load_lane_w = C_data[LANE_MSB:LANE_LSB];
  assign load_en_w   = (state_q == ST_IDLE) && !C_start && (C_op == OP_LOAD_BAL);

  bidsn_argmax #(
    .N     (NUM_BIDDERS),
    .AMT_W (AMT_W)
  ) u_argmax (
    .amt_i   (s_flat_w),
    .start_i (start_w),
    .idx_o   (win_idx_w),
    .amt_o   (win_amt_w),
    .valid_o (win_valid_w)
  );

`ifdef BIDSN_RR_TIEBREAK_EN
  logic [IDX_W-1:0] ptr_q;

  assign start_w = ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if ((state_q == ST_RESOLVE) && win_valid_w) begin
      ptr_q <= (win_idx_w == IDX_W'(NUM_BIDDERS - 1)) ? '0 : win_idx_w + IDX_W'(1);
    end
  end
`else
  assign start_w = '0;
`endif

  always_comb begin
    ack_d = '0;
    win_d = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      bal_d[i]  = bal_q[i];
      s_d[i]    = s_q[i];
      berr_d[i] = BERR_NONE;
      if (state_q == ST_ROUND) begin
        // a retract always executes, even when a bid arrives with it
        if (retract[i]) begin
          bal_d[i] = avail_w[i];
          s_d[i]   = '0;
          ack_d[i] = 1'b1;
          if (bid[i]) berr_d[i] = BERR_REJECT;
        end else if (bid[i]) begin
          if (!mask_q[i] || (amt_w[i] < min_eff_w)) begin
            berr_d[i] = BERR_REJECT;
          end else if (BAL_W'(amt_w[i]) > avail_w[i]) begin
            berr_d[i] = BERR_FUNDS;
          end else begin
            bal_d[i] = avail_w[i] - BAL_W'(amt_w[i]);
            s_d[i]   = amt_w[i];
            ack_d[i] = 1'b1;
          end
        end
      end else begin
        if (bid[i] || retract[i]) berr_d[i] = BERR_STATE;
        if (state_q == ST_RESOLVE) begin
          s_d[i] = '0;
          if (win_valid_w && (win_idx_w == IDX_W'(i))) win_d[i] = 1'b1;
          else bal_d[i] = avail_w[i];
        end
        if (load_en_w && (load_lane_w == 4'(i))) bal_d[i] = C_data[BAL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      mask_q       <= '1;
      min_bid_q    <= '0;
      err_q        <= CERR_NONE;
      round_over_q <= 1'b0;
      max_bid_q    <= '0;
      ack_q        <= '0;
      win_q        <= '0;
      bid_err_q    <= '0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        bal_q[i] <= '0;
        s_q[i]   <= '0;
      end
    end else begin
      ack_q        <= ack_d;
      win_q        <= win_d;
      err_q        <= CERR_NONE;
      round_over_q <= 1'b0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        bal_q[i]             <= bal_d[i];
        s_q[i]               <= s_d[i];
        bid_err_q[2*i +: 2]  <= berr_d[i];
      end
      case (state_q)
        ST_IDLE: begin
          if (C_op > OP_MAX) begin
            err_q <= CERR_BAD_OP;
          end else if (C_start) begin
            if (mask_q == '0) begin
              err_q <= CERR_NO_MASK;
            end else begin
              state_q <= ST_ROUND;
              ready_q <= 1'b0;
            end
          end else begin
            case (C_op)
              OP_LOAD_BAL: if (int'(load_lane_w) >= NUM_BIDDERS) err_q <= CERR_BAD_LANE;
              OP_SET_MASK: mask_q    <= C_data[NUM_BIDDERS-1:0];
              OP_SET_MIN:  min_bid_q <= C_data[AMT_W-1:0];
              default: ;
            endcase
          end
        end
        ST_ROUND: begin
          if (C_op > OP_MAX) err_q <= CERR_BAD_OP;
          else if (C_op != OP_NOP) err_q <= CERR_NOT_IDLE;
          if (!C_start) state_q <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          if (C_op > OP_MAX) err_q <= CERR_BAD_OP;
          else if (C_op != OP_NOP) err_q <= CERR_NOT_IDLE;
          round_over_q <= 1'b1;
          max_bid_q    <= win_valid_w ? win_amt_w : '0;
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign win       = win_q;
  assign bidErr    = bid_err_q;
  assign err       = err_q;
  assign ready     = ready_q;
  assign roundOver = round_over_q;
  assign maxBid    = max_bid_q;

endmodule

// File: tb/tb_bidsn_engine.sv
// Bench for bidsn_engine: directed scenarios then random traffic, checked
// cycle by cycle against an escrow/auction reference model.
module tb_bidsn_engine;

  localparam int N     = 4;
  localparam int AMT_W = 16;
  localparam int BAL_W = 28;

  logic                   clk;
  logic                   reset_n;
  logic [N-1:0]           bid;
  logic [N-1:0]           retract;
  logic [N*AMT_W-1:0]     bidAmt;
  logic                   C_start;
  logic [3:0]             C_op;
  logic [31:0]            C_data;
  logic [N-1:0]           ack;
  logic [N-1:0]           win;
  logic [2*N-1:0]         bidErr;
  logic [2:0]             err;
  logic                   ready;
  logic                   roundOver;
  logic [N*BAL_W-1:0]     balance;
  logic [AMT_W-1:0]       maxBid;

  bidsn_engine #(
    .NUM_BIDDERS (N),
    .AMT_W       (AMT_W),
    .BAL_W       (BAL_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bid       (bid),
    .retract   (retract),
    .bidAmt    (bidAmt),
    .C_start   (C_start),
    .C_op      (C_op),
    .C_data    (C_data),
    .ack       (ack),
    .win       (win),
    .bidErr    (bidErr),
    .err       (err),
    .ready     (ready),
    .roundOver (roundOver),
    .balance   (balance),
    .maxBid    (maxBid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nmis = 0;

  // reference model: plain integers, phase 0 idle / 1 round / 2 resolve
  int m_bal [N];
  int m_s   [N];
  int m_mask, m_min, m_phase, m_ptr, m_maxbid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i] = 0;
      m_s[i]   = 0;
    end
    m_mask = (1 << N) - 1;
    m_min = 0; m_phase = 0; m_ptr = 0; m_maxbid = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"},       128'(ack),       128'(0));
    chk({tag, "_win"},       128'(win),       128'(0));
    chk({tag, "_bidErr"},    128'(bidErr),    128'(0));
    chk({tag, "_err"},       128'(err),       128'(0));
    chk({tag, "_ready"},     128'(ready),     128'(1));
    chk({tag, "_roundOver"}, 128'(roundOver), 128'(0));
    chk({tag, "_maxBid"},    128'(maxBid),    128'(0));
    chk({tag, "_balance"},   128'(balance),   128'(0));
  endtask

  task automatic tick();
    logic [N-1:0]       e_ack, e_win;
    logic [2*N-1:0]     e_berr;
    logic [N*BAL_W-1:0] e_bal;
    int e_err, e_ro, nph, amt, best, w, j, lane, minv;
    @(posedge clk);
    #1;
    e_ack = '0; e_win = '0; e_berr = '0; e_err = 0; e_ro = 0; nph = m_phase;
    minv = (m_min == 0) ? 1 : m_min;
    for (int i = 0; i < N; i++) begin
      amt = int'(bidAmt[i*AMT_W +: AMT_W]);
      if (m_phase == 1) begin
        if (retract[i]) begin
          m_bal[i] = m_bal[i] + m_s[i];
          m_s[i] = 0;
          e_ack[i] = 1'b1;
          if (bid[i]) e_berr[2*i +: 2] = 2'd3;
        end else if (bid[i]) begin
          if (!m_mask[i] || amt < minv) e_berr[2*i +: 2] = 2'd3;
          else if (amt > m_bal[i] + m_s[i]) e_berr[2*i +: 2] = 2'd2;
          else begin
            m_bal[i] = m_bal[i] + m_s[i] - amt;
            m_s[i] = amt;
            e_ack[i] = 1'b1;
          end
        end
      end else if (bid[i] || retract[i]) begin
        e_berr[2*i +: 2] = 2'd1;
      end
    end
    if (m_phase == 2) begin
      best = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_s[j] > best) begin
          best = m_s[j];
          w = j;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!(best > 0 && i == w)) m_bal[i] = m_bal[i] + m_s[i];
        m_s[i] = 0;
      end
      m_maxbid = best;
      e_ro = 1;
      if (best > 0) begin
        e_win[w] = 1'b1;
`ifdef BIDSN_RR_TIEBREAK_EN
        m_ptr = (w + 1) % N;
`endif
      end
      nph = 0;
    end
    if (C_op > 4'd3) e_err = 1;
    else if (m_phase != 0 && C_op != 4'd0) e_err = 2;
    else if (m_phase == 0) begin
      if (C_start) begin
        if (m_mask == 0) e_err = 4;
        else nph = 1;
      end else begin
        case (C_op)
          4'd1: begin
            lane = int'(C_data[31:28]);
            if (lane >= N) e_err = 3;
            else m_bal[lane] = int'(C_data[BAL_W-1:0]);
          end
          4'd2: m_mask = int'(C_data[N-1:0]);
          4'd3: m_min = int'(C_data[AMT_W-1:0]);
          default: ;
        endcase
      end
    end
    if (m_phase == 1 && !C_start) nph = 2;
    m_phase = nph;
    for (int i = 0; i < N; i++) e_bal[i*BAL_W +: BAL_W] = BAL_W'(m_bal[i]);
    chk("ack",       128'(ack),       128'(e_ack));
    chk("win",       128'(win),       128'(e_win));
    chk("bidErr",    128'(bidErr),    128'(e_berr));
    chk("err",       128'(err),       128'(e_err));
    chk("ready",     128'(ready),     128'(m_phase == 0));
    chk("roundOver", 128'(roundOver), 128'(e_ro));
    chk("maxBid",    128'(maxBid),    128'(m_maxbid));
    chk("balance",   128'(balance),   128'(e_bal));
  endtask

  task automatic clr();
    bid = '0; retract = '0; bidAmt = '0; C_op = 4'd0; C_data = '0;
  endtask

  task automatic op_idle(input logic [3:0] op, input logic [31:0] d);
    clr(); C_start = 1'b0; C_op = op; C_data = d; tick();
  endtask

  task automatic lane_req(input int l, input int a, input bit b, input bit r);
    clr(); bid[l] = b; retract[l] = r; bidAmt[l*AMT_W +: AMT_W] = AMT_W'(a); tick();
  endtask

  task automatic start_round();
    clr(); C_start = 1'b1; tick();
  endtask

  task automatic end_round();
    clr(); C_start = 1'b0; tick(); tick();
  endtask

  task automatic tie_300();
    clr();
    bid[0] = 1'b1; bid[1] = 1'b1;
    bidAmt[0 +: AMT_W] = 16'd300; bidAmt[AMT_W +: AMT_W] = 16'd300;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; C_start = 1'b0; clr();
    model_reset();
    #23;
    chk_reset("reset");
    @(negedge clk); reset_n = 1'b1;

    op_idle(4'd1, 32'h2000_03E8);
    op_idle(4'd1, 32'h9000_0005);
    op_idle(4'd7, 32'h0);
    op_idle(4'd1, 32'h0000_01F4);
    op_idle(4'd1, 32'h1000_0190);
    start_round(); tie_300(); end_round();
    op_idle(4'd1, 32'h0000_01F4);
    op_idle(4'd1, 32'h1000_0190);
    start_round(); tie_300(); end_round();

    op_idle(4'd1, 32'h0000_01F4);
    start_round();
    lane_req(0, 200, 1'b1, 1'b0);
    lane_req(0, 450, 1'b1, 1'b0);
    lane_req(0, 600, 1'b1, 1'b0);
    lane_req(0, 0,   1'b0, 1'b1);
    end_round();

    op_idle(4'd3, 32'd100);
    start_round();
    lane_req(1, 99,  1'b1, 1'b0);
    lane_req(1, 100, 1'b1, 1'b0);
    end_round();
    op_idle(4'd2, 32'hD);
    start_round();
    lane_req(1, 150, 1'b1, 1'b0);
    end_round();
    op_idle(4'd2, 32'hF);
    op_idle(4'd3, 32'd0);

    lane_req(2, 50, 1'b1, 1'b0);
    start_round();
    lane_req(0, 100, 1'b1, 1'b1);
    clr(); C_op = 4'd2; C_data = 32'h1; tick();
    end_round();

    op_idle(4'd2, 32'h0);
    clr(); C_start = 1'b1; tick();
    op_idle(4'd2, 32'hF);
    start_round(); end_round();

    for (int n = 0; n < 400; n++) begin
      clr();
      if ($urandom_range(0, 7) == 0) C_start = ~C_start;
      if (m_phase == 0 && !C_start) begin
        case ($urandom_range(0, 5))
          0: begin C_op = 4'd1; C_data = {4'($urandom_range(0, 5)), 28'($urandom_range(0, 2000))}; end
          1: begin C_op = 4'd2; C_data = 32'($urandom_range(0, 15)); end
          2: begin C_op = 4'd3; C_data = 32'($urandom_range(0, 150)); end
          3: C_op = 4'($urandom_range(4, 15));
          default: ;
        endcase
      end else if ($urandom_range(0, 19) == 0) begin
        C_op = 4'($urandom_range(1, 15));
      end
      for (int i = 0; i < N; i++) begin
        bid[i]     = ($urandom_range(0, 9) < 3);
        retract[i] = ($urandom_range(0, 9) == 0);
        bidAmt[i*AMT_W +: AMT_W] = AMT_W'($urandom_range(0, 700));
      end
      tick();
    end

    // abort a round with a standing bid via asynchronous reset
    end_round();
    op_idle(4'd2, 32'hF);
    op_idle(4'd3, 32'd0);
    op_idle(4'd1, 32'h0000_03E8);
    start_round();
    lane_req(0, 100, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_reset("async_rst");
    @(posedge clk); #1;
    chk_reset("rst_hold");
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    clr(); C_start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/bidsn_engine.md
# bidsn_engine

Parametrised N-bidder auction engine, the successor to the fixed three-bidder (X/Y/Z) bids22 core. It uses the same controller model: C_op/C_data configuration while idle, and a round bounded by C_start. Per-bidder balances are held in escrow while a bid stands, and a refund happens on replacement, retraction or loss. It sits behind the bids22inf-style controller task layer, with bidder lanes generalised to vectors.

## Interface
- NUM_BIDDERS, 4: bidder lanes, 2..16.
- AMT_W, 16: bid amount width.
- BAL_W, 28: balance width, must be ≥ AMT_W and ≤ 28.
- clk  in  1: the block's single clock.
- reset_n  in  1: reset, asynchronous and active-low.
- bid  in  N: per-lane bid strobe.
- retract  in  N: per-lane retract strobe.
- bidAmt  in  N×AMT_W: per-lane amount, sampled with bid.
- C_start  in  1: round-active level.
- C_op  in  4: control opcode.
- C_data  in  32: control operand.
- ack  out  N: per-lane request accepted (pulse).
- win  out  N: per-lane round-winner flag (pulse).
- bidErr  out  N×2: per-lane error code.
- err  out  3: control error code.
- ready  out  1: engine idle, accepts ops.
- roundOver  out  1: round resolved (pulse).
- balance  out  N×BAL_W: current per-lane balance.
- maxBid  out  AMT_W: winning amount of the last round.

## Operation
- States: IDLE, ROUND, RESOLVE. Transitions:
  - IDLE→ROUND when C_start=1 and mask≠0.
  - ROUND→RESOLVE when C_start=0.
  - RESOLVE→IDLE unconditionally.
- Ops are honoured only in IDLE with C_start=0:
  - 0 NOP.
  - 1 LOAD_BAL: lane = C_data[31:28], balance = C_data[BAL_W-1:0].
  - 2 SET_MASK: enables = C_data[N-1:0].
  - 3 SET_MIN: minBid = C_data[AMT_W-1:0].
- Control err codes, registered, valid for one cycle, else 0:
  - 1: op >3.
  - 2: nonzero op outside IDLE.
  - 3: lane index ≥ N.
  - 4: C_start with mask=0; the engine stays in IDLE.
- Bid rules, in ROUND only; each lane holds at most one standing bid S:
  - Accept when amt ≥ max(minBid,1) and amt ≤ balance+S.
  - On accept: balance ← balance+S−amt, S ← amt, ack.
- Retract: balance ← balance+S, S ← 0, ack. A retract with S=0 still acks.
- bidErr codes, else 0:
  - 1: request outside ROUND.
  - 2: insufficient balance.
  - 3: lane disabled, amount below minimum, or bid and retract in the same cycle. In the same-cycle case the retract executes, it acks, and bidErr=3.
- RESOLVE:
  - Winner is the highest nonzero S; tie-break is set by the configuration below.
  - The winner keeps its deduction. All other S are refunded. All S clear.
  - maxBid ← winning S, or 0 if there is no bid; in that case no win is asserted.
- Arithmetic:
  - balance+S never overflows. LOAD_BAL is refused in-round, so the total is bounded by the loaded value.
  - Comparisons are unsigned.

## Timing
- Reset values:
  - state IDLE, ready=1.
  - ack, win, bidErr, err, roundOver, maxBid, all S, all balances = 0.
  - mask all ones, minBid=0.
- Reset mid-round aborts immediately with no refunds; balances clear.
- ack/bidErr/err appear one cycle after the sampling edge and last one cycle.
- C_start sampled 0 at edge k → RESOLVE after k. At edge k+1: win/roundOver pulse for one cycle, balances and maxBid updated, state returns to IDLE, ready=1.
- Bids arriving on the cycle C_start is sampled 0 are still processed as ROUND requests; they are resolved in the same RESOLVE.
- ready=0 in ROUND and RESOLVE.

## Configuration
- BIDSN_RR_TIEBREAK_EN defined: ties go to the first tied lane at or after a rotating pointer. The pointer advances to winner+1 (mod N) after each won round and resets to 0.
- Undefined: ties go to the lowest-index lane, and no pointer register exists.

## Structure
- bidsn_pkg holds:
  - the state enum;
  - the op enum (NOP, LOAD_BAL, SET_MASK, SET_MIN);
  - the bidder and control error enums;
  - the C_data field positions.
- Sub-module bidsn_argmax: combinational max/arg-max over N lanes with a priority-start input (tie-break pointer, tied to 0 when the macro is off). Outputs are the index, the amount and a valid flag.

## Test plan
- Reset, then LOAD_BAL lane 2=1000 (C_data=0x2000_03E8) → err=0, balance[2]=1000. LOAD_BAL lane 9 with N=4 → err=3.
- Round: lane0 bids 300 (bal 500), lane1 bids 300 (bal 400). Drop C_start → win[0] pulse, maxBid=300, balance0=200, balance1=400 (refunded). With the macro on, the next identical tie goes to lane1.
- Lane0 bal 500 bids 200 then 450 → both ack, balance=50. Bid 600 → bidErr=2, balance still 50. Retract → balance=500.
- SET_MIN 100, lane1 bids 99 → bidErr=3; bid 100 → ack. SET_MASK 0b1101, lane1 bids → bidErr=3.
- Bid while IDLE → bidErr=1. Same-cycle bid and retract → ack, bidErr=3, S=0. C_op=2 during ROUND → err=2, mask unchanged.
- Round with no bids → roundOver pulse, win=0, maxBid=0. Reset_n asserted mid-round → all outputs zero next edge, ready=1.
